// File: rtl/automat_pkg.sv
// automat_pkg: shared types and helpers for the drink-vending controller.
//   state_t    : controller states (IDLE, DISPENSE, CHANGE)
//   COIN_M*    : coin face values in credit units
//   coin_sum   : total value of the coins pulsed in one cycle
//   onehot_sel : one-hot check and bit index of an 8-bit button vector
package automat_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  localparam logic [3:0] COIN_M1 = 4'd1;
  localparam logic [3:0] COIN_M2 = 4'd2;
  localparam logic [3:0] COIN_M5 = 4'd5;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } sel_t;

  function automatic logic [3:0] coin_sum(input logic m1, input logic m2, input logic m5);
    logic [3:0] s;
    s = '0;
    if (m1) s = s + COIN_M1;
    if (m2) s = s + COIN_M2;
    if (m5) s = s + COIN_M5;
    return s;
  endfunction

  // valid only when exactly one bit is set; idx is meaningful only then
  function automatic sel_t onehot_sel(input logic [7:0] b);
    sel_t r;
    r.valid = (b != 8'd0) && ((b & (b - 8'd1)) == 8'd0);
    r.idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r.idx = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/automat_credit.sv
// automat_credit: credit register of the vending controller.
//   clk, reset  : clock, asynchronous active-high reset (credit -> 0)
//   coin_sum_i  : value of coins presented this cycle
//   add_en      : accept coins this cycle if they fit
//   sub_en      : subtract price this cycle
//   price       : price of the accepted selection
//   dec_en      : decrement credit by one (change payout)
//   credit      : current credit
//   coin_fits   : credit + coin_sum does not exceed the register maximum
// Requires CREDIT_W >= 3 so that the widest coin sum fits the adder.
module automat_credit
  import automat_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          coin_sum_i,
  input  logic                add_en,
  input  logic                sub_en,
  input  logic [CREDIT_W-1:0] price,
  input  logic                dec_en,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_fits
);

  localparam logic [CREDIT_W:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W:0]   sum_w;

  always_comb begin
    // overflow check uses the pre-purchase credit, one bit wider
    sum_w     = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_sum_i);
    coin_fits = (sum_w <= MAX_CREDIT);
    credit_d  = credit_q;
    if (sub_en)              credit_d = credit_d - price;
    if (add_en && coin_fits) credit_d = credit_d + CREDIT_W'(coin_sum_i);
    if (dec_en)              credit_d = credit_d - CREDIT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) credit_q <= '0;
    else       credit_q <= credit_d;
  end

  assign credit = credit_q;

endmodule

// File: rtl/automat_bauturi_n.sv
// automat_bauturi_n: parametrised drink-vending controller.
//   clk, reset     : clock, asynchronous active-high reset
//   B              : selection buttons (level)
//   M1, M2, M5     : coin pulses worth 1, 2, 5 units
//   CANCEL         : refund request
//   EB             : one-hot dispense strobe, DISP_CYCLES cycles long
//   ER             : change pulse, one unit per high cycle
//   REJ            : coins rejected this cycle
//   BUSY           : controller not idle
//   CREDIT         : current credit
//   EMPTY          : per-drink out-of-stock flags
// Optional feature: define AUTOMAT_STOCK_EN to build per-drink stock counters
// initialised to STOCK_INIT; without it stock is unlimited and EMPTY is 0.
module automat_bauturi_n
  import automat_pkg::*;
#(
  parameter int                             NUM_DRINKS  = 3,
  parameter int                             CREDIT_W    = 6,
  parameter logic [NUM_DRINKS*CREDIT_W-1:0] PRICES      = {6'd8, 6'd5, 6'd3},
  parameter int                             DISP_CYCLES = 2,
  parameter int                             STOCK_INIT  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_DRINKS-1:0] B,
  input  logic                  M1,
  input  logic                  M2,
  input  logic                  M5,
  input  logic                  CANCEL,
  output logic [NUM_DRINKS-1:0] EB,
  output logic                  ER,
  output logic                  REJ,
  output logic                  BUSY,
  output logic [CREDIT_W-1:0]   CREDIT,
  output logic [NUM_DRINKS-1:0] EMPTY
);

  localparam int CNT_W = (DISP_CYCLES < 2) ? 1 : $clog2(DISP_CYCLES);

  state_t                state_q, state_d;
  logic [2:0]            sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_DRINKS-1:0] eb_q, eb_d;
  logic                  er_q, er_d;
  logic                  rej_q, rej_d;
  logic                  busy_q, busy_d;

  logic [3:0]            cs;
  logic                  any_coin;
  logic [7:0]            b_ext;
  sel_t                  oh;
  logic [CREDIT_W-1:0]   price_sel;
  logic                  sel_empty;
  logic                  idx_ok;
  logic                  sel_ok;
  logic                  cancel_ok;
  logic                  disp_on;
  logic                  add_en, sub_en, dec_en;
  logic [CREDIT_W-1:0]   credit;
  logic                  coin_fits;
  logic [NUM_DRINKS-1:0] empty_w;

  automat_credit #(
    .CREDIT_W (CREDIT_W)
  ) u_credit (
    .clk        (clk),
    .reset      (reset),
    .coin_sum_i (cs),
    .add_en     (add_en),
    .sub_en     (sub_en),
    .price      (price_sel),
    .dec_en     (dec_en),
    .credit     (credit),
    .coin_fits  (coin_fits)
  );

  // Selection decode and credit control strobes
  always_comb begin
    cs       = coin_sum(M1, M2, M5);
    any_coin = M1 | M2 | M5;
    b_ext    = '0;
    b_ext[NUM_DRINKS-1:0] = B;
    oh       = onehot_sel(b_ext);

    price_sel = '0;
    sel_empty = 1'b0;
    idx_ok    = 1'b0;
    for (int i = 0; i < NUM_DRINKS; i++) begin
      if (oh.idx == 3'(i)) begin
        price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_empty = empty_w[i];
        idx_ok    = 1'b1;
      end
    end

    // price is checked against the credit before this cycle's coins
    sel_ok    = (state_q == IDLE) && oh.valid && idx_ok &&
                (credit >= price_sel) && !sel_empty;
    cancel_ok = (state_q == IDLE) && CANCEL && (credit != '0) && !sel_ok;

    add_en = (state_q == IDLE);
    sub_en = sel_ok;
    dec_en = (state_q == CHANGE) && (credit != '0);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    er_d    = 1'b0;
    disp_on = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_ok) begin
          state_d = DISPENSE;
          sel_d   = oh.idx;
          cnt_d   = CNT_W'(DISP_CYCLES - 1);
          disp_on = 1'b1;
        end else if (cancel_ok) begin
          state_d = CHANGE;
          er_d    = 1'b1;
        end
      end
      DISPENSE: begin
        // cnt_q counts remaining EB cycles after the current one
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CNT_W'(1);
          disp_on = 1'b1;
        end else if (credit != '0) begin
          state_d = CHANGE;
          er_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        // the unit paid this cycle is the last one when credit is 1
        if (credit <= CREDIT_W'(1)) state_d = IDLE;
        else                        er_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    eb_d = '0;
    for (int i = 0; i < NUM_DRINKS; i++) begin
      eb_d[i] = disp_on && (sel_d == 3'(i));
    end

    rej_d  = any_coin && ((state_q != IDLE) || !coin_fits);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      eb_q    <= '0;
      er_q    <= 1'b0;
      rej_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      eb_q    <= eb_d;
      er_q    <= er_d;
      rej_q   <= rej_d;
      busy_q  <= busy_d;
    end
  end

`ifdef AUTOMAT_STOCK_EN
  localparam int SW = (STOCK_INIT < 2) ? 1 : $clog2(STOCK_INIT + 1);

  logic [NUM_DRINKS-1:0][SW-1:0] stock_q, stock_d;
  logic [NUM_DRINKS-1:0]         empty_q, empty_d;

  // stock is consumed on the cycle the selection is accepted
  always_comb begin
    stock_d = stock_q;
    empty_d = '0;
    for (int i = 0; i < NUM_DRINKS; i++) begin
      if (sel_ok && (oh.idx == 3'(i)) && (stock_q[i] != '0))
        stock_d[i] = stock_q[i] - SW'(1);
      empty_d[i] = (stock_d[i] == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DRINKS; i++) stock_q[i] <= SW'(STOCK_INIT);
      empty_q <= {NUM_DRINKS{(STOCK_INIT == 0)}};
    end else begin
      stock_q <= stock_d;
      empty_q <= empty_d;
    end
  end

  assign empty_w = empty_q;
`else
  logic unused_stock_init;
  assign unused_stock_init = (STOCK_INIT != 0);
  assign empty_w = '0;
`endif

  assign EB     = eb_q;
  assign ER     = er_q;
  assign REJ    = rej_q;
  assign BUSY   = busy_q;
  assign CREDIT = credit;
  assign EMPTY  = empty_w;

endmodule

// File: tb/tb_automat_bauturi_n.sv
// Self-checking bench for automat_bauturi_n: directed vectors, a plan-queue
// reference model checked every cycle, plus hand-computed literal checks.
// Define AUTOMAT_STOCK_EN to also exercise the stock feature (STOCK_INIT=1).
module tb_automat_bauturi_n;

  localparam int N    = 3;
  localparam int CW   = 6;
  localparam int MAXC = 63;
  localparam int DISP = 2;
`ifdef AUTOMAT_STOCK_EN
  localparam int SINIT = 1;
  localparam bit STOCK_MODE = 1'b1;
`else
  localparam int SINIT = 4;
  localparam bit STOCK_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  B = '0;
  logic          M1 = 1'b0, M2 = 1'b0, M5 = 1'b0, CANCEL = 1'b0;
  logic [N-1:0]  EB;
  logic          ER, REJ, BUSY;
  logic [CW-1:0] CREDIT;
  logic [N-1:0]  EMPTY;

  int n_tests = 0;
  int n_fail  = 0;

  automat_bauturi_n #(.STOCK_INIT(SINIT)) dut (
    .clk(clk), .reset(reset), .B(B), .M1(M1), .M2(M2), .M5(M5),
    .CANCEL(CANCEL), .EB(EB), .ER(ER), .REJ(REJ), .BUSY(BUSY),
    .CREDIT(CREDIT), .EMPTY(EMPTY)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // While busy, the model holds the exact sequence of future output cycles.
  typedef struct {
    int eb;   // drink index dispensed that cycle, -1 for none
    bit er;   // change unit paid that cycle
  } ent_t;

  ent_t plan[$];
  int   m_credit = 0;
  bit   m_rej = 1'b0;
  int   m_stock[N];
  int   price_m[N] = '{3, 5, 8};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      plan.delete();
      m_credit = 0;
      m_rej    = 1'b0;
      for (int i = 0; i < N; i++) m_stock[i] = STOCK_MODE ? SINIT : 1000000;
    end else begin
      int   coins, acc, nb, idx;
      bit   anyc, fits, ok;
      ent_t e;
      coins = (M1 ? 1 : 0) + (M2 ? 2 : 0) + (M5 ? 5 : 0);
      anyc  = M1 || M2 || M5;
      if (plan.size() > 0) begin
        m_rej = anyc;
        e = plan.pop_front();
        if (e.er) m_credit = m_credit - 1;
      end else begin
        fits  = (m_credit + coins) <= MAXC;
        m_rej = anyc && !fits;
        acc   = fits ? coins : 0;
        nb    = $countones(B);
        idx   = 0;
        for (int i = 0; i < N; i++) if (B[i]) idx = i;
        ok = (nb == 1) && (m_credit >= price_m[idx]) && (m_stock[idx] > 0);
        if (ok) begin
          m_credit = m_credit - price_m[idx] + acc;
          m_stock[idx] = m_stock[idx] - 1;
          for (int k = 0; k < DISP; k++) begin e.eb = idx; e.er = 1'b0; plan.push_back(e); end
          for (int k = 0; k < m_credit; k++) begin e.eb = -1; e.er = 1'b1; plan.push_back(e); end
        end else if (CANCEL && m_credit > 0) begin
          m_credit = m_credit + acc;
          for (int k = 0; k < m_credit; k++) begin e.eb = -1; e.er = 1'b1; plan.push_back(e); end
        end else begin
          m_credit = m_credit + acc;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      logic [N-1:0] x_eb, x_empty;
      logic x_er, x_busy;
      logic [2*N+3+CW-1:0] got, exp_v;
      x_eb = '0; x_er = 1'b0; x_empty = '0;
      if (plan.size() > 0) begin
        if (plan[0].eb >= 0) x_eb[plan[0].eb] = 1'b1;
        x_er = plan[0].er;
      end
      x_busy = plan.size() > 0;
      for (int i = 0; i < N; i++) x_empty[i] = (m_stock[i] == 0);
      got   = {EB, ER, REJ, BUSY, CREDIT, EMPTY};
      exp_v = {x_eb, x_er, m_rej, x_busy, CW'(m_credit), x_empty};
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t got EB/ER/REJ/BUSY/CREDIT/EMPTY=%b/%b/%b/%b/%0d/%b required %b/%b/%b/%b/%0d/%b",
                 $time, EB, ER, REJ, BUSY, CREDIT, EMPTY,
                 x_eb, x_er, m_rej, x_busy, m_credit, x_empty);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic cyc(input logic [N-1:0] b, input logic m1, input logic m2,
                     input logic m5, input logic c);
    B = b; M1 = m1; M2 = m2; M5 = m5; CANCEL = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    cyc('0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!BUSY) break;
      idle1();
    end
    chk("wait_idle_timeout", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int ercnt;
    idle1();
    idle1();
    chk("reset_credit", CREDIT, 0);
    chk("reset_outs", {EB, ER, REJ, BUSY}, 0);
    reset = 1'b0;

    // M2, M2, buy drink 0 (price 3)
    cyc('0, 0, 1, 0, 0);
    cyc('0, 0, 1, 0, 0);
    chk("credit_4", CREDIT, 4);
    cyc(3'b001, 0, 0, 0, 0);
    chk("buy0_eb", EB, 3'b001);
    chk("buy0_credit", CREDIT, 1);
    idle1();
    chk("buy0_eb2", EB, 3'b001);
    idle1();
    chk("buy0_er", {EB, ER}, 4'b0001);
    idle1();
    chk("buy0_done", {ER, BUSY, CREDIT}, 0);

    // drink 2 (price 8): insufficient, then enough, coin during dispense
    cyc('0, 0, 0, 1, 0);
    cyc(3'b100, 0, 0, 0, 0);
    chk("buy2_low_credit", CREDIT, 5);
    chk("buy2_low_eb", {EB, BUSY}, 0);
    cyc('0, 0, 0, 1, 0);
    chk("credit_10", CREDIT, 10);
    cyc(3'b100, 0, 0, 0, 0);
    chk("buy2_eb", EB, 3'b100);
    chk("buy2_credit", CREDIT, 2);
    cyc('0, 1, 0, 0, 0);
    chk("disp_coin_rej", {EB, REJ}, 4'b1001);
    chk("disp_coin_credit", CREDIT, 2);
    idle1();
    chk("buy2_er1", {EB, ER, REJ, CREDIT}, {3'b000, 1'b1, 1'b0, 6'd2});
    idle1();
    chk("buy2_er2", {ER, CREDIT}, {1'b1, 6'd1});
    idle1();
    chk("buy2_done", {ER, BUSY, CREDIT}, 0);

    // multi-button ignored, then cancel refunds 10
    cyc('0, 0, 0, 1, 0);
    cyc('0, 0, 0, 1, 0);
    cyc(3'b011, 0, 0, 0, 0);
    chk("multi_btn_eb", {EB, BUSY}, 0);
    chk("multi_btn_credit", CREDIT, 10);
    cyc('0, 0, 0, 0, 1);
    ercnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!BUSY) break;
      if (ER) ercnt++;
      idle1();
    end
    chk("cancel_er_count", ercnt, 10);
    chk("cancel_done", {BUSY, CREDIT}, 0);

    // valid selection beats cancel; selection with simultaneous coin
    cyc('0, 0, 0, 1, 0);
    cyc(3'b010, 0, 0, 0, 1);
    chk("sel_over_cancel", {EB, ER, CREDIT}, {3'b010, 1'b0, 6'd0});
    wait_idle(10);
    cyc('0, 1, 1, 0, 0);
    cyc(3'b001, 0, 0, 1, 0);
    chk("sel_plus_coin", {EB, CREDIT}, {3'b001, 6'd5});
    wait_idle(20);

    // coin boundaries
    cyc('0, 1, 0, 1, 0);
    chk("m1_m5_same", CREDIT, 6);
    for (int i = 0; i < 11; i++) cyc('0, 0, 0, 1, 0);
    cyc('0, 1, 0, 0, 0);
    chk("credit_62", CREDIT, 62);
    cyc('0, 0, 1, 0, 0);
    chk("ovf_rej", {REJ, CREDIT}, {1'b1, 6'd62});
    cyc('0, 1, 0, 0, 0);
    chk("credit_63", {REJ, CREDIT}, {1'b0, 6'd63});
    cyc('0, 0, 0, 0, 1);
    wait_idle(80);
    cyc('0, 0, 0, 0, 1);
    chk("cancel_zero", {BUSY, ER}, 0);

    // reset mid-change
    cyc('0, 0, 0, 1, 0);
    cyc('0, 0, 1, 0, 0);
    cyc('0, 0, 0, 0, 1);
    idle1();
    idle1();
    chk("change_3rd", {ER, CREDIT}, {1'b1, 6'd5});
    reset = 1'b1;
    #1;
    chk("async_reset", {ER, BUSY, CREDIT}, 0);
    idle1();
    reset = 1'b0;

`ifdef AUTOMAT_STOCK_EN
    cyc('0, 1, 0, 1, 0);
    cyc(3'b001, 0, 0, 0, 0);
    chk("stock_buy_eb", {EB, EMPTY}, {3'b001, 3'b001});
    wait_idle(20);
    cyc('0, 1, 0, 0, 0);
    cyc('0, 0, 1, 0, 0);
    cyc(3'b001, 0, 0, 0, 0);
    chk("stock_empty_ignored", {EB, BUSY, CREDIT}, {3'b000, 1'b0, 6'd3});
    cyc('0, 0, 0, 0, 1);
    wait_idle(20);
`endif

    idle1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
